// File: rtl/armaria_mem_pkg.sv
// Shared encodings for the byte-serial data-memory sequencer.
// Carries op codes, the empty-stack marker, FSM states and the per-request plan.
package armaria_mem_pkg;

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_BYTE = 3'd3;
  localparam logic [2:0] OP_HALF = 3'd4;
  localparam logic [2:0] OP_WORD = 3'd5;

  localparam logic [31:0] EMPTY_SP = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // last_idx is N-1: the index of the final byte of the access.
  typedef struct packed {
    logic [31:0] base;
    logic [1:0]  last_idx;
    logic        is_write;
    logic        is_stack;
    logic [31:0] new_sp;
    logic        fault;
    logic [31:0] fault_rdata;
  } plan_t;

endpackage

// File: rtl/mem_access_planner.sv
// Combinational request decode: base address, byte count, direction, new SP and fault.
// Zero latency; no flow control, evaluated every cycle and sampled by the sequencer at start.
module mem_access_planner
  import armaria_mem_pkg::*;
#(
  parameter logic [31:0] USER_TOP = 32'h17FF,
  parameter logic [31:0] USER_BOT = 32'h1000,
  parameter logic [31:0] PRIV_TOP = 32'h1FFF,
  parameter logic [31:0] PRIV_BOT = 32'h1800
) (
  input  logic [2:0]  op,
  input  logic        write,
  input  logic        M,
  input  logic [31:0] SP,
  input  logic [31:0] address,
  output plan_t       plan
);

  logic [31:0] top;
  logic [31:0] bot;

  assign top = M ? PRIV_TOP : USER_TOP;
  assign bot = M ? PRIV_BOT : USER_BOT;

  always_comb begin
    plan        = '0;
    plan.new_sp = SP;
    case (op)
      OP_PUSH: begin
        plan.is_stack = 1'b1;
        plan.is_write = 1'b1;
        plan.last_idx = 2'd3;
        if (SP == EMPTY_SP) begin
          plan.base   = top;
          plan.new_sp = top;
        end else if (SP >= bot + 32'd7) begin
          // Compared as SP >= BOT+7 so a tiny SP cannot wrap past the bound.
          plan.base   = SP - 32'd4;
          plan.new_sp = SP - 32'd4;
        end else begin
          plan.fault = 1'b1;
        end
      end
      OP_POP: begin
        plan.is_stack = 1'b1;
        plan.last_idx = 2'd3;
        if (SP == top) begin
          plan.base   = top;
          plan.new_sp = EMPTY_SP;
        end else if (SP >= bot + 32'd3 && SP < top) begin
          plan.base   = SP;
          plan.new_sp = SP + 32'd4;
        end else begin
          plan.fault       = 1'b1;
          plan.fault_rdata = EMPTY_SP;
          plan.new_sp      = EMPTY_SP;
        end
      end
      OP_BYTE: begin
        plan.base     = address;
        plan.is_write = write;
        plan.last_idx = 2'd0;
      end
      OP_HALF: begin
        plan.base     = address;
        plan.is_write = write;
        plan.last_idx = 2'd1;
      end
      OP_WORD: begin
        plan.base     = address;
        plan.is_write = write;
        plan.last_idx = 2'd3;
      end
      default: plan.fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Serialises PUSH/POP/byte/half/word requests into byte RAM cycles; writes take N+1 cycles, reads N+2, faults 1.
// No backpressure: start is only sampled in IDLE and is dropped while busy.
module memory_access_sequencer
  import armaria_mem_pkg::*;
#(
  parameter logic [31:0] USER_TOP = 32'h17FF,
  parameter logic [31:0] USER_BOT = 32'h1000,
  parameter logic [31:0] PRIV_TOP = 32'h1FFF,
  parameter logic [31:0] PRIV_BOT = 32'h1800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        write,
  input  logic        M,
  input  logic [31:0] SP,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] SPout,
  output logic        sp_we
);

  plan_t       plan;
  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  last_idx;
  logic        is_write;
  logic        is_stack;
  logic [31:0] new_sp;
  logic [31:0] wbuf;
  logic [31:0] asm_q;

  mem_access_planner #(
    .USER_TOP(USER_TOP),
    .USER_BOT(USER_BOT),
    .PRIV_TOP(PRIV_TOP),
    .PRIV_BOT(PRIV_BOT)
  ) u_planner (
    .op      (op),
    .write   (write),
    .M       (M),
    .SP      (SP),
    .address (address),
    .plan    (plan)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      last_idx  <= 2'd0;
      is_write  <= 1'b0;
      is_stack  <= 1'b0;
      new_sp    <= 32'd0;
      wbuf      <= 32'd0;
      asm_q     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'd0;
      SPout     <= 32'd0;
      sp_we     <= 1'b0;
    end else begin
      done  <= 1'b0;
      sp_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= 2'd0;
            last_idx <= plan.last_idx;
            is_write <= plan.is_write;
            is_stack <= plan.is_stack;
            new_sp   <= plan.new_sp;
            wbuf     <= wdata;
            asm_q    <= 32'd0;
            busy     <= 1'b1;
            if (plan.fault) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= plan.fault_rdata;
              SPout <= plan.new_sp;
              sp_we <= plan.is_stack;
            end else begin
              state     <= ISSUE;
              mem_addr  <= plan.base;
              mem_we    <= plan.is_write;
              mem_wdata <= plan.is_write ? wdata[7:0] : 8'd0;
            end
          end
        end
        ISSUE: begin
          // RAM data lags the address by one cycle, so this edge sees byte cnt-1.
          if (!is_write && cnt != 2'd0)
            asm_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
          if (cnt == last_idx) begin
            mem_addr  <= 32'd0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'd0;
            if (is_write) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b0;
              rdata <= 32'd0;
              SPout <= new_sp;
              sp_we <= is_stack;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt       <= cnt + 2'd1;
            mem_addr  <= mem_addr - 32'd1;
            mem_wdata <= is_write ? wbuf[{cnt + 2'd1, 3'b000} +: 8] : 8'd0;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
          fault <= 1'b0;
          rdata <= asm_q | ({24'd0, mem_rdata} << {cnt, 3'b000});
          SPout <= new_sp;
          sp_we <= is_stack;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench with a byte RAM model and write/result scoreboards.
module tb_memory_access_sequencer;

  localparam logic [2:0] P_PUSH = 3'd1, P_POP = 3'd2, P_BYTE = 3'd3, P_HALF = 3'd4, P_WORD = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        write = 1'b0;
  logic        M = 1'b0;
  logic [31:0] SP = 32'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [7:0]  mem_rdata = 8'd0;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] SPout;
  logic        sp_we;

  memory_access_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .write(write), .M(M),
    .SP(SP), .address(address), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy),
    .done(done), .fault(fault), .rdata(rdata), .SPout(SPout), .sp_we(sp_we)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] spout;
    logic        sp_we;
    int          lat;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic [7:0] ram [0:8191];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_we) ram[mem_addr[12:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[12:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (mem_we) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, w.data});
        end
      end
      if (done || sp_we) begin
        chk("done_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          res_t r;
          r = rq.pop_front();
          chk("done", {31'd0, done}, 32'd1);
          chk("busy_in_done", {31'd0, busy}, 32'd1);
          chk("fault", {31'd0, fault}, {31'd0, r.fault});
          chk("rdata", rdata, r.rdata);
          chk("SPout", SPout, r.spout);
          chk("sp_we", {31'd0, sp_we}, {31'd0, r.sp_we});
          chk("latency", 32'(cyc - start_cyc), 32'(r.lat));
        end
      end
    end
  end

  task automatic exp_writes(input logic [31:0] base, input logic [31:0] data, input int n);
    for (int k = 0; k < n; k++) begin
      wr_t w;
      w.addr = base - 32'(k);
      w.data = data[8*k +: 8];
      wq.push_back(w);
    end
  endtask

  task automatic exp_res(input logic f, input logic [31:0] rd, input logic [31:0] spo,
                         input logic spw, input int lat);
    res_t r;
    r.fault = f; r.rdata = rd; r.spout = spo; r.sp_we = spw; r.lat = lat;
    rq.push_back(r);
  endtask

  task automatic issue(input logic [2:0] o, input logic wr, input logic m,
                       input logic [31:0] sp, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clock);
    op = o; write = wr; M = m; SP = sp; address = addr; wdata = wd; start = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clock);
    chk("results_drained", 32'(rq.size()), 32'd0);
    chk("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    ram[13'h200] = 8'h34;
    ram[13'h1FF] = 8'h12;

    #12;
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_SPout", SPout, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // PUSH onto empty user stack
    exp_writes(32'h17FF, 32'hA1B2C3D4, 4);
    exp_res(1'b0, 32'd0, 32'h17FF, 1'b1, 4);
    issue(P_PUSH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hA1B2C3D4);
    wait_idle();

    // POP it back
    exp_res(1'b0, 32'hA1B2C3D4, 32'hFFFF_FFFF, 1'b1, 5);
    issue(P_POP, 1'b0, 1'b0, 32'h17FF, 32'd0, 32'd0);
    wait_idle();

    // PUSH overflow below user bottom
    exp_res(1'b1, 32'd0, 32'h1006, 1'b1, 0);
    issue(P_PUSH, 1'b0, 1'b0, 32'h1006, 32'd0, 32'hDEADBEEF);
    wait_idle();

    // Halfword load
    exp_res(1'b0, 32'h0000_1234, 32'h1234_5678, 1'b0, 3);
    issue(P_HALF, 1'b0, 1'b0, 32'h1234_5678, 32'h200, 32'd0);
    wait_idle();

    // POP on empty privileged stack
    exp_res(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    issue(P_POP, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    wait_idle();

    // PUSH onto non-empty privileged stack, then POP it
    exp_writes(32'h1FFB, 32'h11223344, 4);
    exp_res(1'b0, 32'd0, 32'h1FFB, 1'b1, 4);
    issue(P_PUSH, 1'b0, 1'b1, 32'h1FFF, 32'd0, 32'h11223344);
    wait_idle();
    exp_res(1'b0, 32'h11223344, 32'h1FFF, 1'b1, 5);
    issue(P_POP, 1'b0, 1'b1, 32'h1FFB, 32'd0, 32'd0);
    wait_idle();

    // Byte load zero-extends
    exp_res(1'b0, 32'h0000_0044, 32'h55, 1'b0, 2);
    issue(P_BYTE, 1'b0, 1'b0, 32'h55, 32'h1FFB, 32'd0);
    wait_idle();

    // Illegal op
    exp_res(1'b1, 32'd0, 32'h0000_0ABC, 1'b0, 0);
    issue(3'd7, 1'b1, 1'b0, 32'h0000_0ABC, 32'h300, 32'hFFFF_FFFF);
    wait_idle();

    // Word store with a start pulse while busy that must be dropped
    exp_writes(32'h300, 32'hCAFEBABE, 4);
    exp_res(1'b0, 32'd0, 32'h77, 1'b0, 4);
    issue(P_WORD, 1'b1, 1'b0, 32'h77, 32'h300, 32'hCAFEBABE);
    @(negedge clock);
    op = P_BYTE; write = 1'b1; address = 32'h600; wdata = 32'h99; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    exp_res(1'b0, 32'hCAFEBABE, 32'h77, 1'b0, 5);
    issue(P_WORD, 1'b0, 1'b0, 32'h77, 32'h300, 32'd0);
    wait_idle();

    // Reset in cycle 2 of a word store
    exp_writes(32'h400, 32'h01020304, 2);
    issue(P_WORD, 1'b1, 1'b0, 32'h88, 32'h400, 32'h01020304);
    @(negedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sp_we", {31'd0, sp_we}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    chk("abort_writes_seen", 32'(wq.size()), 32'd0);
    chk("abort_byte2_untouched", {24'd0, ram[13'h3FE]}, 32'd0);
    exp_writes(32'h500, 32'h0000_005A, 1);
    exp_res(1'b0, 32'd0, 32'h88, 1'b0, 1);
    issue(P_BYTE, 1'b1, 1'b0, 32'h88, 32'h500, 32'h0000_005A);
    wait_idle();
    chk("byte_store_ram", {24'd0, ram[13'h500]}, 32'h5A);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
